debounce_sync_bank: RTL and testbench

Multi-channel input conditioner for buttons, switches and external async strobes. Each channel passes through a parametrised synchroniser chain and then a tick-gated debounce counter. Outputs are a debounced level plus one-cycle rise, fall and any-change pulses. Sits between board pins and the control FSMs, replacing per-pin synchroniser and debounce pairs.

---
 rtl/debounce_sync_bank_pkg.sv | 23 ++
 rtl/debounce_sync_bank_channel.sv | 70 +++++++
 rtl/debounce_sync_bank.sv | 56 +++++
 tb/tb_debounce_sync_bank.sv | 204 ++++++++++++++++++++
 4 files changed

// File: rtl/debounce_sync_bank_pkg.sv
// Shared constants and helpers for the debounce/synchroniser bank.
// Elaboration-time helpers only; no logic lives here.
package debounce_sync_bank_pkg;

  localparam int DEF_CHANNELS        = 4;
  localparam int DEF_SYNC_STAGES     = 2;
  localparam int DEF_DEBOUNCE_CYCLES = 16;
  localparam bit DEF_INIT_LEVEL      = 1'b0;
  localparam bit DEF_ACTIVE_LOW      = 1'b0;

  // Counter must hold 0..DEBOUNCE_CYCLES-1; sized for DEBOUNCE_CYCLES+1 values.
  function automatic int cnt_width(input int cycles);
    int w;
    w = $clog2(cycles + 1);
    return (w < 1) ? 1 : w;
  endfunction

  function automatic bit params_ok(input int channels, input int sync_stages,
                                   input int debounce_cycles);
    return (channels >= 1) && (sync_stages >= 2) && (debounce_cycles >= 1);
  endfunction

endpackage

// File: rtl/debounce_sync_bank_channel.sv
// One channel: synchroniser chain, tick-gated debounce counter, stable level
// and registered rise/fall pulses. accept_o is the combinational acceptance strobe.
module debounce_sync_bank_channel
  import debounce_sync_bank_pkg::*;
#(
  parameter int SYNC_STAGES     = DEF_SYNC_STAGES,
  parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
  parameter bit INIT_LEVEL      = DEF_INIT_LEVEL
) (
  input  logic clk_in,
  input  logic rst_in,
  input  logic raw_i,
  input  logic tick_i,
  output logic level_o,
  output logic rise_o,
  output logic fall_o,
  output logic accept_o
);

  localparam int            CW       = cnt_width(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   stable_q, stable_d;
  logic [CW-1:0]          cnt_q, cnt_d;
  logic                   rise_q, fall_q;
  logic                   sync_w, mismatch, accept;

  assign sync_w   = sync_q[SYNC_STAGES-1];
  assign mismatch = (sync_w != stable_q);
  assign accept   = mismatch && tick_i && (cnt_q == CNT_LAST);

  always_comb begin
    stable_d = stable_q;
    cnt_d    = cnt_q;
    if (!mismatch) begin
      cnt_d = '0;
    end else if (tick_i) begin
      if (accept) begin
        stable_d = sync_w;
        cnt_d    = '0;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      sync_q   <= {SYNC_STAGES{INIT_LEVEL}};
      stable_q <= INIT_LEVEL;
      cnt_q    <= '0;
      rise_q   <= 1'b0;
      fall_q   <= 1'b0;
    end else begin
      sync_q   <= {sync_q[SYNC_STAGES-2:0], raw_i};
      stable_q <= stable_d;
      cnt_q    <= cnt_d;
      // Pulses land on the same edge that updates stable_q.
      rise_q   <= accept &  sync_w;
      fall_q   <= accept & ~sync_w;
    end
  end

  assign level_o  = stable_q;
  assign rise_o   = rise_q;
  assign fall_o   = fall_q;
  assign accept_o = accept;

endmodule

// File: rtl/debounce_sync_bank.sv
// Multi-channel input conditioner: per-channel sync + debounce, plus a
// registered any-change pulse aligned with the per-channel rise/fall pulses.
module debounce_sync_bank
  import debounce_sync_bank_pkg::*;
#(
  parameter int CHANNELS        = DEF_CHANNELS,
  parameter int SYNC_STAGES     = DEF_SYNC_STAGES,
  parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
  parameter bit INIT_LEVEL      = DEF_INIT_LEVEL,
  parameter bit ACTIVE_LOW      = DEF_ACTIVE_LOW
) (
  input  logic                clk_in,
  input  logic                rst_in,
  input  logic [CHANNELS-1:0] data_in,
  input  logic                tick_in,
  output logic [CHANNELS-1:0] data_out,
  output logic [CHANNELS-1:0] rise_out,
  output logic [CHANNELS-1:0] fall_out,
  output logic                change_out
);

  if (!params_ok(CHANNELS, SYNC_STAGES, DEBOUNCE_CYCLES)) begin : g_bad_params
    $fatal(1, "debounce_sync_bank: need CHANNELS>=1, SYNC_STAGES>=2, DEBOUNCE_CYCLES>=1");
  end

  logic [CHANNELS-1:0] raw;
  logic [CHANNELS-1:0] accept;
  logic                change_q;

  assign raw = data_in ^ {CHANNELS{ACTIVE_LOW}};

  for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
    debounce_sync_bank_channel #(
      .SYNC_STAGES    (SYNC_STAGES),
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
      .INIT_LEVEL     (INIT_LEVEL)
    ) u_ch (
      .clk_in  (clk_in),
      .rst_in  (rst_in),
      .raw_i   (raw[i]),
      .tick_i  (tick_in),
      .level_o (data_out[i]),
      .rise_o  (rise_out[i]),
      .fall_o  (fall_out[i]),
      .accept_o(accept[i])
    );
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) change_q <= 1'b0;
    else        change_q <= |accept;
  end

  assign change_out = change_q;

endmodule

// File: tb/tb_debounce_sync_bank.sv
// Bench for debounce_sync_bank: two instances (default polarity, and
// INIT_LEVEL=1/ACTIVE_LOW=1) checked every cycle against a tick-counting model.
module tb_debounce_sync_bank;

  localparam int SYNC = 2;
  localparam int DEB  = 16;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       tick = 1'b1;
  logic [3:0] din0 = 4'b0000;
  logic [3:0] din1 = 4'b1111;
  logic [3:0] dout0, rise0, fall0, dout1, rise1, fall1;
  logic       chg0, chg1;

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;

  always #5 clk = ~clk;

  debounce_sync_bank #(.CHANNELS(4), .SYNC_STAGES(SYNC), .DEBOUNCE_CYCLES(DEB),
                       .INIT_LEVEL(1'b0), .ACTIVE_LOW(1'b0)) u_dut0 (
    .clk_in(clk), .rst_in(rst), .data_in(din0), .tick_in(tick),
    .data_out(dout0), .rise_out(rise0), .fall_out(fall0), .change_out(chg0));

  debounce_sync_bank #(.CHANNELS(4), .SYNC_STAGES(SYNC), .DEBOUNCE_CYCLES(DEB),
                       .INIT_LEVEL(1'b1), .ACTIVE_LOW(1'b1)) u_dut1 (
    .clk_in(clk), .rst_in(rst), .data_in(din1), .tick_in(tick),
    .data_out(dout1), .rise_out(rise1), .fall_out(fall1), .change_out(chg1));

  // Model: the sync output is the raw level SYNC edges old; a channel accepts
  // once DEB ticks have been seen while that level disagrees with stable.
  bit m_pipe [2][4][SYNC];
  bit m_stab [2][4];
  int m_held [2][4];
  bit [3:0] m_rise [2];
  bit [3:0] m_fall [2];
  bit       m_chg  [2];

  task automatic model_edge(input int u, input logic [3:0] din, input bit tk, input bit r);
    bit init, al, s;
    init = (u == 1);
    al   = (u == 1);
    m_rise[u] = '0;
    m_fall[u] = '0;
    for (int c = 0; c < 4; c++) begin
      if (r) begin
        for (int k = 0; k < SYNC; k++) m_pipe[u][c][k] = init;
        m_stab[u][c] = init;
        m_held[u][c] = 0;
      end else begin
        s = m_pipe[u][c][SYNC-1];
        if (s == m_stab[u][c]) m_held[u][c] = 0;
        else if (tk) begin
          m_held[u][c]++;
          if (m_held[u][c] == DEB) begin
            m_stab[u][c] = s;
            m_held[u][c] = 0;
            m_rise[u][c] = s;
            m_fall[u][c] = !s;
          end
        end
        for (int k = SYNC-1; k > 0; k--) m_pipe[u][c][k] = m_pipe[u][c][k-1];
        m_pipe[u][c][0] = din[c] ^ al;
      end
    end
    m_chg[u] = !r && ((m_rise[u] | m_fall[u]) != 0);
  endtask

  function automatic logic [12:0] exp_vec(input int u);
    logic [3:0] st;
    for (int c = 0; c < 4; c++) st[c] = m_stab[u][c];
    return {st, m_rise[u], m_fall[u], m_chg[u]};
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s cyc=%0d observed=%h expected=%h", tag, cyc, obs, exp);
    end
  endtask

  task automatic step();
    model_edge(0, din0, tick, rst);
    model_edge(1, din1, tick, rst);
    @(posedge clk);
    #1;
    cyc++;
    check("u0_outputs", 32'({dout0, rise0, fall0, chg0}), 32'(exp_vec(0)));
    check("u1_outputs", 32'({dout1, rise1, fall1, chg1}), 32'(exp_vec(1)));
  endtask

  // Edges from the first sampling edge until rise0[ch] is seen (bounded).
  task automatic edges_to_rise0(input int ch, output int n);
    n = 0;
    for (int k = 0; k < 60; k++) begin
      step();
      n++;
      if (rise0[ch]) break;
    end
  endtask

  initial begin
    int n;
    bit seen;

    // Reset
    rst = 1'b1;
    repeat (3) step();
    check("rst_dout0", 32'(dout0), 32'h0);
    check("rst_dout1", 32'(dout1), 32'hF);
    check("rst_pulses", 32'({rise0, fall0, chg0, rise1, fall1, chg1}), 32'h0);
    rst = 1'b0;
    step();
    check("post_rst_no_pulse", 32'({rise0, fall0, chg0, rise1, fall1, chg1}), 32'h0);

    // Clean press on ch0
    din0[0] = 1'b1;
    edges_to_rise0(0, n);
    check("press_latency", 32'(n), 32'd18);
    check("press_change", 32'({chg0, dout0[0]}), 32'b11);
    step();
    check("press_one_cycle", 32'({rise0[0], chg0}), 32'b00);

    // Bounce on ch1: toggles every 5 clocks, then held high
    seen = 1'b0;
    for (int k = 0; k < 40; k++) begin
      if (k % 5 == 0) din0[1] = ~din0[1];
      step();
      seen |= rise0[1] | fall0[1];
    end
    check("bounce_no_pulse", 32'(seen), 32'd0);
    din0[1] = 1'b1;
    edges_to_rise0(1, n);
    check("bounce_latency", 32'(n), 32'd18);

    // Tick gating on ch2: bring high first, then 1->0 with sparse ticks
    din0[2] = 1'b1;
    repeat (22) step();
    din0[2] = 1'b0;
    for (int k = 0; k < 24; k++) begin
      tick = (k % 4 == 0);
      step();
    end
    tick = 1'b0;
    seen = 1'b0;
    for (int k = 0; k < 30; k++) begin
      step();
      seen |= fall0[2];
    end
    check("no_tick_no_accept", 32'(seen), 32'd0);
    seen = 1'b0;
    for (int k = 0; k < 120 && !seen; k++) begin
      tick = (k % 4 == 0);
      step();
      seen = fall0[2];
    end
    check("tick_gated_fall", 32'({seen, dout0[2]}), 32'b10);
    tick = 1'b1;

    // Active-low, simultaneous acceptance on ch0 and ch3 of instance 1
    din1 = 4'b0110;
    seen = 1'b0;
    for (int k = 0; k < 40 && !seen; k++) begin
      step();
      seen = (rise1 != 4'b0000);
    end
    check("simul_rise", 32'({rise1, fall1, chg1}), 32'b1001_0000_1);
    step();
    check("simul_one_cycle", 32'({rise1, chg1, dout1}), 32'b0000_0_1001);

    // Reset mid-count on ch0: bring it low, then start a rise and abort it
    din0[0] = 1'b0;
    repeat (20) step();
    din0[0] = 1'b1;
    seen = 1'b0;
    repeat (12) begin
      step();
      seen |= rise0[0];
    end
    rst = 1'b1;
    step();
    seen |= rise0[0] | chg0;
    check("midrst_no_pulse", 32'({seen, dout0[0]}), 32'b00);
    rst = 1'b0;
    edges_to_rise0(0, n);
    check("midrst_latency", 32'(n), 32'd18);

    // Random phase
    for (int k = 0; k < 600; k++) begin
      if ($urandom_range(0, 7) == 0) din0[$urandom_range(0, 3)] ^= 1'b1;
      if ($urandom_range(0, 7) == 0) din1[$urandom_range(0, 3)] ^= 1'b1;
      tick = ($urandom_range(0, 3) != 0);
      rst  = ($urandom_range(0, 299) == 0);
      step();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
